pipelined_cla_adder: RTL

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_if.sv | 28 ++
 rtl/pipelined_cla_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The producer/consumer side uses master; the adder uses slave.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Add/subtract split into STAGES carry-lookahead segments, one segment per pipeline stage.
// Stage k adds slice k using the carry registered by stage k-1; the last stage is the output register.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  // Flat two-level lookahead: each carry is an OR of generate terms gated by propagate runs.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic c0);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           term;
    logic           pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & c0);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_ovf;
  logic             r_zero;

  logic             w_v     [STAGES];
  logic [WIDTH-1:0] w_a     [STAGES];
  logic [WIDTH-1:0] w_b     [STAGES];
  logic [WIDTH-1:0] w_s     [STAGES];
  logic             w_c     [STAGES];
  logic [SEG:0]     w_seg   [STAGES];
  logic [WIDTH-1:0] w_nxt_s [STAGES];
  logic             w_nxt_c [STAGES];
  logic             w_en;
  logic             w_ovf;
  logic             w_zero;

  assign w_en = !r_v[STAGES-1] || bus.out_ready;

  // Stage inputs: stage 0 sees the port (B already inverted for subtract), later stages
  // see the previous stage's delayed operands, partial sum and segment carry.
  always_comb begin
    w_v[0] = bus.in_valid;
    w_a[0] = bus.a;
    w_b[0] = bus.sub ? ~bus.b : bus.b;
    w_c[0] = bus.sub | bus.cin;
    w_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_v[k] = r_v[k-1];
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_c[k] = r_c[k-1];
      w_s[k] = r_s[k-1];
    end
  end

  // NOTE: every always_comb output is given a full value before any partial overwrite,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_seg[k]                    = cla_seg(w_a[k][k*SEG +: SEG], w_b[k][k*SEG +: SEG], w_c[k]);
      w_nxt_s[k]                  = w_s[k];
      w_nxt_s[k][k*SEG +: SEG]    = w_seg[k][SEG-1:0];
      w_nxt_c[k]                  = w_seg[k][SEG];
    end
  end

  assign w_ovf  = (w_a[STAGES-1][WIDTH-1] == w_b[STAGES-1][WIDTH-1]) &&
                  (w_nxt_s[STAGES-1][WIDTH-1] != w_a[STAGES-1][WIDTH-1]);
  assign w_zero = (w_nxt_s[STAGES-1] == '0);

  // NOTE: state is updated with non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
    end else if (w_en) begin
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_v[k];
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_s[k] <= w_nxt_s[k];
        r_c[k] <= w_nxt_c[k];
      end
    end
  end

  assign bus.in_ready  = w_en && !rst;
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.sum       = r_s[STAGES-1];
  assign bus.cout      = r_c[STAGES-1];
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule
